// File: rtl/cache_victim_sel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_victim_sel_pkg                                         |
// | Description : Shared definitions for the victim selector: FSM state        |
// |               encodings, default geometry and the way-index width helper.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package cache_victim_sel_pkg;

  localparam int c_DEF_WAYS  = 4;
  localparam int c_DEF_AGE_W = 32;
  localparam int c_DEF_IDX_W = 3;

  localparam int c_STATE_W = 2;

  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a way index; never narrower than one bit.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/victim_age_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : victim_age_cmp                                               |
// | Description : Per-cycle scan decision for one way of the addressed set.    |
// |   age      in  AGE_W   age counter value of the way under the pointer     |
// |   valid    in  1       line valid bit of that way                         |
// |   best_age in  AGE_W   oldest age seen so far in this scan                |
// |   ptr      in  WAY_W   way currently being scanned                        |
// |   take     out 1       this way becomes the current best candidate        |
// |   stop     out 1       scan ends after this way                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module victim_age_cmp
  import cache_victim_sel_pkg::*;
#(
  parameter int WAYS  = c_DEF_WAYS,
  parameter int AGE_W = c_DEF_AGE_W,
  parameter int WAY_W = way_w(WAYS)
) (
  input  logic [AGE_W-1:0] age,
  input  logic             valid,
  input  logic [AGE_W-1:0] best_age,
  input  logic [WAY_W-1:0] ptr,
  output logic             take,
  output logic             stop
);

  localparam logic [WAY_W-1:0] c_LAST_WAY = WAY_W'(WAYS - 1);

  // An invalid way is taken unconditionally and ends the scan, so the lowest
  // invalid way wins. Way 0 always seeds the candidate so a set whose ages are
  // all zero still yields a defined victim. Strict unsigned '>' keeps the lower
  // way on ties.
  assign take = !valid || (ptr == '0) || (age > best_age);
  assign stop = !valid || (ptr == c_LAST_WAY);

endmodule
`default_nettype wire

// File: rtl/cache_victim_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_victim_sel                                             |
// | Description : Replacement victim selector. Scans one way per cycle of the  |
// |               addressed set: first invalid way, else the oldest way.       |
// |               Returns the victim on a valid/ready handshake and pulses a   |
// |               one-hot clear to that way's age counter on acceptance.      |
// |   clk          in  1            rising-edge clock                         |
// |   rst          in  1            asynchronous active-high reset            |
// |   req_valid    in  1            miss requests a victim for req_index      |
// |   req_index    in  IDX_W        set index of the miss                     |
// |   req_ready    out 1            idle, request can be accepted             |
// |   line_valid   in  WAYS         valid bits of the addressed set           |
// |   age_data     in  WAYS*AGE_W   age counters, way i at [i*AGE_W +: AGE_W] |
// |   cnt_index    out IDX_W        set index driven to all counter banks     |
// |   cnt_clr      out WAYS         one-hot clear of the victim's counter     |
// |   victim_valid out 1            victim_way holds a result                 |
// |   victim_way   out WAY_W        selected way                              |
// |   victim_ready in  1            refill logic consumes the victim          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cache_victim_sel
  import cache_victim_sel_pkg::*;
#(
  parameter int WAYS  = c_DEF_WAYS,
  parameter int AGE_W = c_DEF_AGE_W,
  parameter int IDX_W = c_DEF_IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [IDX_W-1:0]          req_index,
  output logic                      req_ready,
  input  logic [WAYS-1:0]           line_valid,
  input  logic [WAYS*AGE_W-1:0]     age_data,
  output logic [IDX_W-1:0]          cnt_index,
  output logic [WAYS-1:0]           cnt_clr,
  output logic                      victim_valid,
  output logic [way_w(WAYS)-1:0]    victim_way,
  input  logic                      victim_ready
);

  localparam int c_WAY_W = way_w(WAYS);

  state_t             r_state,    w_state_nxt;
  logic [IDX_W-1:0]   r_index,    w_index_nxt;
  logic [c_WAY_W-1:0] r_ptr,      w_ptr_nxt;
  logic [AGE_W-1:0]   r_best_age, w_best_age_nxt;
  logic [c_WAY_W-1:0] r_best_way, w_best_way_nxt;

  logic [AGE_W-1:0]   w_ages [WAYS];
  logic [AGE_W-1:0]   w_cur_age;
  logic               w_cur_valid;
  logic               w_take;
  logic               w_stop;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_unpack
    assign w_ages[gi] = age_data[gi*AGE_W +: AGE_W];
  end

  // Counter banks are read combinationally, so the way under the pointer is
  // valid in the same cycle cnt_index presents the latched set.
  assign w_cur_age   = w_ages[r_ptr];
  assign w_cur_valid = line_valid[r_ptr];

  victim_age_cmp #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W),
    .WAY_W (c_WAY_W)
  ) u_age_cmp (
    .age      (w_cur_age),
    .valid    (w_cur_valid),
    .best_age (r_best_age),
    .ptr      (r_ptr),
    .take     (w_take),
    .stop     (w_stop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_ptr      <= '0;
      r_best_age <= '0;
      r_best_way <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_ptr      <= w_ptr_nxt;
      r_best_age <= w_best_age_nxt;
      r_best_way <= w_best_way_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_index_nxt    = r_index;
    w_ptr_nxt      = r_ptr;
    w_best_age_nxt = r_best_age;
    w_best_way_nxt = r_best_way;
    req_ready      = 1'b0;
    cnt_index      = r_index;
    cnt_clr        = '0;
    victim_valid   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        // Present the incoming index straight away so the banks are already
        // addressed for the first scan cycle's neighbour logic.
        cnt_index = req_index;
        if (req_valid) begin
          w_index_nxt    = req_index;
          w_ptr_nxt      = '0;
          w_best_age_nxt = '0;
          w_best_way_nxt = '0;
          w_state_nxt    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (w_take) begin
          w_best_age_nxt = w_cur_age;
          w_best_way_nxt = r_ptr;
        end
        if (w_stop) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_ptr_nxt = r_ptr + c_WAY_W'(1);
        end
      end

      ST_DONE: begin
        victim_valid = 1'b1;
        if (victim_ready) begin
          cnt_clr[r_best_way] = 1'b1;
          w_state_nxt         = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // best_way only moves during SCAN, so the result is stable through DONE.
  assign victim_way = r_best_way;

endmodule
`default_nettype wire

// File: tb/tb_cache_victim_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cache_victim_sel                                          |
// | Description : Scoreboard bench for cache_victim_sel. Stimulus pushes the   |
// |               hand-computed victim and its first-valid cycle; a monitor    |
// |               pops and compares whenever a new victim appears, and checks  |
// |               clear pulses, index routing and result stability per cycle.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cache_victim_sel;

  localparam int WAYS  = 4;
  localparam int AGE_W = 32;
  localparam int IDX_W = 3;
  localparam int WAY_W = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic [IDX_W-1:0]      req_index = '0;
  logic                  req_ready;
  logic [WAYS-1:0]       line_valid = '1;
  logic [WAYS*AGE_W-1:0] age_data = '0;
  logic [IDX_W-1:0]      cnt_index;
  logic [WAYS-1:0]       cnt_clr;
  logic                  victim_valid;
  logic [WAY_W-1:0]      victim_way;
  logic                  victim_ready = 1'b1;

  always #5 clk = ~clk;

  cache_victim_sel #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_index    (req_index),
    .req_ready    (req_ready),
    .line_valid   (line_valid),
    .age_data     (age_data),
    .cnt_index    (cnt_index),
    .cnt_clr      (cnt_clr),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .victim_ready (victim_ready)
  );

  typedef struct {
    int way;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_idx = 0;
  int cur_way  = 0;
  bit mon_en   = 1'b0;
  bit have_cur = 1'b0;
  bit prev_vv  = 1'b0;
  logic [WAYS-1:0] exp_clr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (victim_valid && !prev_vv) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_victim: got way %0d expected none", victim_way);
        end else begin
          m_e = q.pop_front();
          chk("victim_way", 64'(victim_way), 64'(m_e.way));
          chk("victim_latency", 64'(cyc), 64'(m_e.cyc));
          cur_way  = m_e.way;
          have_cur = 1'b1;
        end
      end
      if (victim_valid && have_cur)
        chk("victim_way_stable", 64'(victim_way), 64'(cur_way));
      exp_clr = (victim_valid && victim_ready && have_cur) ? WAYS'(1 << cur_way) : '0;
      chk("cnt_clr", 64'(cnt_clr), 64'(exp_clr));
      if (!req_ready)
        chk("cnt_index_busy", 64'(cnt_index), 64'(busy_idx));
      if (victim_valid && victim_ready)
        have_cur = 1'b0;
      prev_vv = victim_valid;
    end
  end

  // Called #1 after a rising edge while the DUT is idle.
  task automatic issue(input int idx, input logic [WAYS-1:0] lv,
                       input logic [AGE_W-1:0] a0, input logic [AGE_W-1:0] a1,
                       input logic [AGE_W-1:0] a2, input logic [AGE_W-1:0] a3,
                       input int ew, input int lat);
    exp_t e;
    req_index  = IDX_W'(idx);
    line_valid = lv;
    age_data   = {a3, a2, a1, a0};
    req_valid  = 1'b1;
    #1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    chk("cnt_index_idle", 64'(cnt_index), 64'(idx));
    e.way = ew;
    e.cyc = cyc + lat;
    q.push_back(e);
    busy_idx = idx;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for the handshake cycle, then return #1 after the following edge.
  task automatic wait_hs();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (victim_valid && victim_ready) break;
      n++;
      if (n > 30) begin
        total++;
        bad++;
        $display("FAIL handshake_timeout: got no handshake expected one within 30 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vv();
    int n;
    n = 0;
    while (!victim_valid) begin
      @(negedge clk);
      n++;
      if (n > 30) begin
        total++;
        bad++;
        $display("FAIL victim_timeout: got no victim_valid expected one within 30 cycles");
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_victim_valid", 64'(victim_valid), 64'd0);
    chk("rst_victim_way", 64'(victim_way), 64'd0);
    chk("rst_cnt_clr", 64'(cnt_clr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: reset asserted mid-SCAN aborts without a victim or clear pulse
    issue(3, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 3, 5);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_victim_valid", 64'(victim_valid), 64'd0);
    chk("abort_cnt_clr", 64'(cnt_clr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_vv  = 1'b0;
    have_cur = 1'b0;
    @(posedge clk);
    #1;
    chk("post_abort_req_ready", 64'(req_ready), 64'd1);
    chk("post_abort_victim_valid", 64'(victim_valid), 64'd0);
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Test 2: way 2 invalid in set 5
    issue(5, 4'b1011, 32'd9, 32'd8, 32'd100, 32'd7, 2, 4);
    wait_hs();

    // Test 3: tie on the oldest age keeps the lower way
    issue(2, 4'b1111, 32'd10, 32'd40, 32'd7, 32'd40, 1, 5);
    wait_hs();

    // Test 4: unsigned compare, 0xFFFFFFFF is the oldest
    issue(4, 4'b1111, 32'hFFFF_FFFF, 32'd3, 32'd3, 32'd3, 0, 5);
    wait_hs();

    // Invalid way 3 beats a much older valid way 0
    issue(0, 4'b0111, 32'd100, 32'd5, 32'd6, 32'd7, 3, 5);
    wait_hs();

    // Two invalid ways: the lowest wins and the scan stops immediately
    issue(7, 4'b0110, 32'd1, 32'd50, 32'd60, 32'd2, 0, 2);
    wait_hs();

    // All ages zero except the last way
    issue(3, 4'b1111, 32'd0, 32'd0, 32'd0, 32'd1, 3, 5);
    wait_hs();

    // Test 5: back-pressure for 6 cycles with a stray request
    victim_ready = 1'b0;
    issue(2, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 3, 5);
    wait_vv();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_index = 3'd7;
      chk("req_ready_done", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    victim_ready = 1'b1;
    wait_hs();
    chk("idle_after_hs", 64'(req_ready), 64'd1);
    chk("no_vv_after_hs", 64'(victim_valid), 64'd0);

    // Test 6: back-to-back requests, second accepted right after the handshake
    issue(1, 4'b1110, 32'd5, 32'd5, 32'd5, 32'd5, 0, 2);
    wait_hs();
    issue(6, 4'b1111, 32'd5, 32'd5, 32'd5, 32'd5, 0, 5);
    wait_hs();

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
